rgmii_recv: RTL and testbench

//  Receive-side RGMII framer, the receive counterpart of the RGMII transmitter.

---
 rtl/rgmii_pkg.sv | 20 ++
 rtl/rgmii_nibble_pack.sv | 89 ++++++++
 rtl/rgmii_recv.sv | 176 +++++++++++++++++
 tb/tb_rgmii_recv.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// Shared RGMII definitions: framing bytes, gap length and the framer state encoding
// (the transmitter reuses the encoding for its own localparams).
package rgmii_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int unsigned MIN_IFG_BYTES = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rgmii_state_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/rgmii_nibble_pack.sv
// Turns DDR (1G) or single-nibble (100M) RX input into registered byte strobes.
// In 100M mode every dv=0 cycle also strobes, so the framer sees the end of a frame.
module rgmii_nibble_pack (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       speed_1g,
  input  logic [3:0] rx_data_h,
  input  logic [3:0] rx_data_l,
  input  logic       rx_ctl_h,
  input  logic       rx_ctl_l,
  output logic       byte_strobe,
  output logic [7:0] byte_data,
  output logic       byte_dv,
  output logic       byte_er,
  output logic       byte_odd
);

  logic [3:0] half_q, half_d;
  logic       half_er_q, half_er_d;
  logic       phase_q, phase_d;
  logic       strobe_q, strobe_d;
  logic [7:0] data_q, data_d;
  logic       dv_q, dv_d;
  logic       er_q, er_d;
  logic       odd_q, odd_d;
  logic       er_now_s;

  // Byte assembly; odd flags a dangling low nibble when dv falls in 100M.
  always_comb begin
    er_now_s  = rx_ctl_h ^ rx_ctl_l;
    half_d    = half_q;
    half_er_d = half_er_q;
    phase_d   = 1'b0;
    strobe_d  = 1'b0;
    data_d    = data_q;
    dv_d      = 1'b0;
    er_d      = 1'b0;
    odd_d     = 1'b0;
    if (speed_1g) begin
      strobe_d = 1'b1;
      data_d   = {rx_data_l, rx_data_h};
      dv_d     = rx_ctl_h;
      er_d     = er_now_s;
    end else if (!rx_ctl_h) begin
      strobe_d = 1'b1;
      er_d     = er_now_s;
      odd_d    = phase_q;
    end else if (phase_q) begin
      strobe_d = 1'b1;
      data_d   = {rx_data_h, half_q};
      dv_d     = 1'b1;
      er_d     = er_now_s | half_er_q;
    end else begin
      half_d    = rx_data_h;
      half_er_d = er_now_s;
      phase_d   = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      half_q    <= 4'd0;
      half_er_q <= 1'b0;
      phase_q   <= 1'b0;
      strobe_q  <= 1'b0;
      data_q    <= 8'd0;
      dv_q      <= 1'b0;
      er_q      <= 1'b0;
      odd_q     <= 1'b0;
    end else begin
      half_q    <= half_d;
      half_er_q <= half_er_d;
      phase_q   <= phase_d;
      strobe_q  <= strobe_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      er_q      <= er_d;
      odd_q     <= odd_d;
    end
  end

  assign byte_strobe = strobe_q;
  assign byte_data   = data_q;
  assign byte_dv     = dv_q;
  assign byte_er     = er_q;
  assign byte_odd    = odd_q;

endmodule

// File: rtl/rgmii_recv.sv
// RGMII receive framer: strips preamble/SFD, emits payload bytes and reports
// frame end with length and error status.
module rgmii_recv
  import rgmii_pkg::*;
#(
  parameter int unsigned MIN_PREAMBLE = 1,
  parameter int unsigned MAX_FRAME    = 1522
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        speed_1Gbit,
  input  logic [3:0]  rx_data_h,
  input  logic [3:0]  rx_data_l,
  input  logic        rx_ctl_h,
  input  logic        rx_ctl_l,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic        sof,
  output logic        eof,
  output logic [10:0] length,
  output logic        error,
  output logic        active
);

  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME);
  localparam logic [3:0]  MIN_PRE = 4'(MIN_PREAMBLE);

  rgmii_state_e state_q, state_d;
  logic         speed_q, speed_d;
  logic [3:0]   pre_cnt_q, pre_cnt_d;
  logic [10:0]  len_q, len_d;
  logic         err_q, err_d;
  logic [7:0]   data_q, data_d;
  logic         data_valid_q, data_valid_d;
  logic         sof_q, sof_d;
  logic         eof_q, eof_d;
  logic [10:0]  length_q, length_d;
  logic         error_q, error_d;
  logic         active_q, active_d;
  logic         speed_eff_s;
  logic         bs_s, bdv_s, ber_s, bodd_s;
  logic [7:0]   bd_s;

  // Speed follows the pin only while idle; a frame keeps the speed it started with.
  assign speed_eff_s = (state_q == ST_IDLE) ? speed_1Gbit : speed_q;

  rgmii_nibble_pack u_pack (
    .clock       (clock),
    .reset_n     (reset_n),
    .speed_1g    (speed_eff_s),
    .rx_data_h   (rx_data_h),
    .rx_data_l   (rx_data_l),
    .rx_ctl_h    (rx_ctl_h),
    .rx_ctl_l    (rx_ctl_l),
    .byte_strobe (bs_s),
    .byte_data   (bd_s),
    .byte_dv     (bdv_s),
    .byte_er     (ber_s),
    .byte_odd    (bodd_s)
  );

  // Framer next-state and output decode.
  always_comb begin
    state_d      = state_q;
    speed_d      = speed_q;
    pre_cnt_d    = pre_cnt_q;
    len_d        = len_q;
    err_d        = err_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    length_d     = length_q;
    error_d      = error_q;
    active_d     = active_q;
    case (state_q)
      ST_IDLE: begin
        speed_d = speed_1Gbit;
        if (bs_s && bdv_s && (bd_s == PREAMBLE_BYTE)) begin
          state_d   = ST_PREAMBLE;
          pre_cnt_d = 4'd1;
        end else if (bs_s && bdv_s && !speed_q && (bd_s[3:0] == PREAMBLE_BYTE[3:0])) begin
          // 100M: a 0x5 first nibble commits to a preamble, so a bad second nibble drops
          state_d = ST_DROP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (!bs_s) begin
          state_d = ST_PREAMBLE;
        end else if (!bdv_s) begin
          state_d = ST_IDLE;
        end else if (bd_s == PREAMBLE_BYTE) begin
          pre_cnt_d = sat_inc4(pre_cnt_q);
        end else if ((bd_s == SFD_BYTE) && (pre_cnt_q >= MIN_PRE)) begin
          state_d  = ST_DATA;
          active_d = 1'b1;
          len_d    = 11'd0;
          err_d    = 1'b0;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!bs_s) begin
          state_d = ST_DATA;
        end else if (!bdv_s) begin
          eof_d    = 1'b1;
          length_d = len_q;
          error_d  = err_q | bodd_s | (len_q == 11'd0);
          active_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (len_q < MAX_LEN) begin
          data_valid_d = 1'b1;
          data_d       = bd_s;
          sof_d        = (len_q == 11'd0);
          len_d        = len_q + 11'd1;
          err_d        = err_q | ber_s;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_DROP: begin
        if (bs_s && !bdv_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Framer state, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      speed_q      <= 1'b0;
      pre_cnt_q    <= 4'd0;
      len_q        <= 11'd0;
      err_q        <= 1'b0;
      data_q       <= 8'd0;
      data_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      length_q     <= 11'd0;
      error_q      <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      speed_q      <= speed_d;
      pre_cnt_q    <= pre_cnt_d;
      len_q        <= len_d;
      err_q        <= err_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      length_q     <= length_d;
      error_q      <= error_d;
      active_q     <= active_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign length     = length_q;
  assign error      = error_q;
  assign active     = active_q;

endmodule

// File: tb/tb_rgmii_recv.sv
// Self-checking bench for rgmii_recv: directed and random frames compared against
// a frame-level model of preamble/SFD stripping, length limiting and error rules.
module tb_rgmii_recv;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        speed_1Gbit = 1'b1;
  logic [3:0]  rx_data_h = 4'd0;
  logic [3:0]  rx_data_l = 4'd0;
  logic        rx_ctl_h = 1'b0;
  logic        rx_ctl_l = 1'b0;
  logic [7:0]  data;
  logic        data_valid, sof, eof, error, active;
  logic [10:0] length;

  rgmii_recv #(.MIN_PREAMBLE(1), .MAX_FRAME(1522)) dut (
    .clock(clock), .reset_n(reset_n), .speed_1Gbit(speed_1Gbit),
    .rx_data_h(rx_data_h), .rx_data_l(rx_data_l),
    .rx_ctl_h(rx_ctl_h), .rx_ctl_l(rx_ctl_l),
    .data(data), .data_valid(data_valid), .sof(sof), .eof(eof),
    .length(length), .error(error), .active(active)
  );

  always #4 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0]  got_b[$];
  logic [7:0]  exp_b[$];
  logic [11:0] got_e[$];
  logic [11:0] exp_e[$];
  int got_sof = 0, exp_sof = 0, sof_bad = 0, proto_bad = 0, since = 0;
  logic [7:0] fr_b[$];
  bit         fr_er[$];

  // Output monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (sof && !data_valid) proto_bad++;
      if (eof && (sof || data_valid || active)) proto_bad++;
      if (data_valid && !active) proto_bad++;
      if (sof) got_sof++;
      if (data_valid) begin
        if (sof !== (since == 0)) sof_bad++;
        got_b.push_back(data);
        since++;
      end
      if (eof) begin
        got_e.push_back({error, length});
        since = 0;
      end
      if (!reset_n) since = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic cyc(input logic [3:0] h, input logic [3:0] l, input logic ch, input logic cl);
    rx_data_h = h; rx_data_l = l; rx_ctl_h = ch; rx_ctl_l = cl;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic spd, input logic [7:0] b, input logic er);
    if (spd) begin
      cyc(b[3:0], b[7:4], 1'b1, ~er);
    end else begin
      cyc(b[3:0], b[3:0], 1'b1, ~er);
      cyc(b[7:4], b[7:4], 1'b1, ~er);
    end
  endtask

  task automatic build(input int npre, input int npay, input bit seq, input int er_idx);
    fr_b.delete(); fr_er.delete();
    for (int i = 0; i < npre; i++) begin fr_b.push_back(8'h55); fr_er.push_back(1'b0); end
    fr_b.push_back(8'hD5); fr_er.push_back(1'b0);
    for (int i = 0; i < npay; i++) begin
      fr_b.push_back(seq ? 8'(i) : 8'($urandom));
      fr_er.push_back(i == er_idx);
    end
  endtask

  task automatic send_frame(input logic spd, input bit odd, input int gap);
    speed_1Gbit = spd;
    idle(2);
    for (int i = 0; i < fr_b.size(); i++) send_byte(spd, fr_b[i], fr_er[i]);
    if (odd) cyc(4'hA, 4'hA, 1'b1, 1'b1);
    idle(gap);
  endtask

  // Frame-level reference: leading 0x55 run, then SFD, then payload capped at 1522.
  task automatic model(input bit odd);
    int i = 0;
    int n, keep;
    bit err;
    logic [10:0] k11;
    while (i < fr_b.size() && fr_b[i] == 8'h55) i++;
    if (i >= 1 && i < fr_b.size() && fr_b[i] == 8'hD5) begin
      n    = fr_b.size() - i - 1;
      keep = (n > 1522) ? 1522 : n;
      err  = (n > 1522) || (n == 0) || odd;
      for (int j = 0; j < n; j++) if (fr_er[i + 1 + j]) err = 1'b1;
      for (int j = 0; j < keep; j++) exp_b.push_back(fr_b[i + 1 + j]);
      k11 = keep[10:0];
      exp_e.push_back({err, k11});
      if (keep > 0) exp_sof++;
    end
  endtask

  task automatic check_batch(input string tag);
    int mism = 0;
    int m;
    chk({tag, "_nbytes"}, got_b.size(), exp_b.size());
    m = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int j = 0; j < m; j++) if (got_b[j] !== exp_b[j]) mism++;
    chk({tag, "_bytes"}, mism, 0);
    chk({tag, "_neof"}, got_e.size(), exp_e.size());
    m = (got_e.size() < exp_e.size()) ? got_e.size() : exp_e.size();
    for (int j = 0; j < m; j++) begin
      chk({tag, "_len"}, 32'(got_e[j][10:0]), 32'(exp_e[j][10:0]));
      chk({tag, "_err"}, 32'(got_e[j][11]), 32'(exp_e[j][11]));
    end
    chk({tag, "_nsof"}, got_sof, exp_sof);
    chk({tag, "_sofpos"}, sof_bad, 0);
    chk({tag, "_proto"}, proto_bad, 0);
    got_b.delete(); exp_b.delete(); got_e.delete(); exp_e.delete();
    got_sof = 0; exp_sof = 0; sof_bad = 0; proto_bad = 0;
  endtask

  initial begin
    bit spd, odd;
    int npre, npay, eri;
    @(posedge clock); #1;
    idle(3);
    chk("reset_outputs", {data, data_valid, sof, eof, length, error, active}, 0);
    reset_n = 1'b1;
    idle(2);

    build(7, 64, 1'b1, -1); send_frame(1'b1, 1'b0, 4); model(1'b0); check_batch("t1_1g");
    build(7, 64, 1'b1, -1); send_frame(1'b0, 1'b0, 4); model(1'b0); check_batch("t2_100m");
    build(7, 64, 1'b1, 10); send_frame(1'b1, 1'b0, 4); model(1'b0); check_batch("t3_rxer");

    build(2, 20, 1'b1, -1);
    fr_b.insert(2, 8'hAA); fr_er.insert(2, 1'b0);
    send_frame(1'b1, 1'b0, 3); model(1'b0);
    build(7, 32, 1'b0, -1); send_frame(1'b1, 1'b0, 4); model(1'b0);
    check_batch("t4_badpre");

    build(7, 1530, 1'b1, -1); send_frame(1'b1, 1'b0, 4); model(1'b0); check_batch("t5_oversize");

    build(7, 20, 1'b1, -1);
    speed_1Gbit = 1'b1; idle(2);
    for (int i = 0; i < fr_b.size(); i++) send_byte(1'b1, fr_b[i], fr_er[i]);
    reset_n = 1'b0;
    #1;
    chk("t6_reset_now", {data, data_valid, sof, eof, length, error, active}, 0);
    chk("t6_partial_seen", (got_b.size() >= 18 && got_b.size() <= 20), 1);
    got_b.delete(); got_sof = 0;
    idle(3);
    reset_n = 1'b1;
    idle(3);
    check_batch("t6_no_eof");
    build(7, 48, 1'b0, -1); send_frame(1'b0, 1'b0, 4); model(1'b0); check_batch("t6_after");

    build(3, 0, 1'b1, -1); send_frame(1'b1, 1'b0, 4); model(1'b0); check_batch("zero_len");
    build(20, 15, 1'b0, -1); send_frame(1'b0, 1'b1, 4); model(1'b1); check_batch("odd_nibble");

    build(1, 10, 1'b0, -1); send_frame(1'b1, 1'b0, 0); idle(1); model(1'b0);
    build(1, 12, 1'b0, -1);
    for (int i = 0; i < fr_b.size(); i++) send_byte(1'b1, fr_b[i], fr_er[i]);
    idle(4); model(1'b0);
    check_batch("back2back");

    for (int r = 0; r < 8; r++) begin
      spd  = 1'($urandom % 2);
      npre = 1 + int'($urandom % 20);
      npay = 1 + int'($urandom % 100);
      eri  = ($urandom % 4 == 0) ? int'($urandom % npay) : -1;
      odd  = !spd && ($urandom % 4 == 0);
      build(npre, npay, 1'b0, eri);
      send_frame(spd, odd, 3 + int'($urandom % 4));
      model(odd);
      check_batch("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
